s2p_frame_ctrl: RTL and testbench
=================================

// Module: s2p_frame_ctrl
// PURPOSE
//   Frame sequencer for the serial-to-parallel path in the clk_s domain. Hunts a sync
//   pattern in the serial stream, then cuts the following bits into WIDTH-bit words,
//   WORDS_PER_FRAME words per frame. Presents each word on a valid/ready handshake
//   toward the parallel consumer; flags overrun when that consumer stalls.
// PARAMETERS
//   WIDTH            4        bits per parallel word; also the sync pattern length
//   SYNC_PATTERN     4'b1011  pattern, MSB first, that marks start of frame
//   WORDS_PER_FRAME  8        data words per frame after sync (>=1)
// PORTS
//   clk_s        in   1      serial bit clock; all logic is on its rising edge
//   reset_n      in   1      asynchronous, active-low reset
//   enable       in   1      bit qualifier; serial bit sampled only when 1
//   signal       in   1      serial data, MSB first
//   resync       in   1      synchronous; forces HUNT on the next edge
//   code         out  WIDTH  parallel word; stable while code_valid && !code_ready
//   code_valid   out  1      word available
//   code_ready   in   1      consumer accepts the word when valid && ready
//   frame_start  out  1      1-cycle pulse with the first word of a frame
//   frame_end    out  1      1-cycle pulse with the last word of a frame
//   overrun      out  1      sticky: a completed word was dropped
//   clr_overrun  in   1      synchronous clear of overrun
//   locked       out  1      1 while the state is DATA
// BEHAVIOUR
//   Reset: shifter, counters, code = 0; code_valid, frame_start, frame_end, overrun,
//     locked = 0; state = HUNT. Reset mid-frame abandons the frame; no partial word.
//   Shifter: on enable, sh <= {sh[WIDTH-2:0], signal}. With enable=0 the shifter,
//     counters and state hold. The handshake still runs.
//   HUNT: on an enabled edge where the next shifter value == SYNC_PATTERN, go to DATA
//     with bit_cnt = 0 and word_cnt = 0. The sync bits are not output.
//   DATA: bit_cnt increments on each enabled edge. When bit_cnt == WIDTH-1 the word
//     completes: bit_cnt wraps to 0 and word_cnt increments.
//     - On the last word (word_cnt == WORDS_PER_FRAME-1), go to HUNT and clear word_cnt.
//   Word completion: the word is the next shifter value. It is registered into code on
//     the same edge, with code_valid=1 in the next cycle.
//     - Latency: 1 cycle after the edge that samples the word's last bit.
//     - frame_start / frame_end pulse in the same cycle that code_valid first shows the
//       first / last word. Both pulse together when WORDS_PER_FRAME = 1.
//     - Both pulse only if the word is accepted into code (see drop rule below).
//   Handshake: the transfer happens on an edge where code_valid && code_ready.
//     - code_valid clears after a transfer unless a new word completes on that same
//       edge. In that case code loads the new word and code_valid stays 1 (no bubble).
//     - code_valid never drops without a transfer.
//   Drop rule: if a word completes while code_valid=1 and code_ready=0, keep the old
//     code, discard the new word and set overrun. Sequencing still advances.
//     - A dropped last word still returns the state to HUNT, with no frame_end pulse.
//   overrun: sticky. clr_overrun clears it. If a set and a clear occur on the same edge,
//     the set wins.
//   resync: state <= HUNT and counters <= 0. The shifter keeps shifting. code and
//     code_valid are unaffected. If a word completes on the same edge, resync wins:
//     the word is discarded and overrun is not set.
//   Sync pattern inside the data payload is ignored; no re-hunt until the frame ends.
//   Widths: bit_cnt is $clog2(WIDTH) bits; word_cnt is $clog2(WORDS_PER_FRAME+1) bits.
// STRUCTURE
//   Shared package s2p_pkg:
//     - typedef enum logic {HUNT, DATA} s2p_state_t
//     - default WIDTH and SYNC_PATTERN constants
//   Sub-module s2p_out_stage: a single-entry valid/ready holding register plus the
//   overrun logic. The top level holds the shifter, the counters and the FSM.
// TESTING
//   1 Reset, then stream 1011 followed by 0001..1000 (8 words), ready=1:
//     -> codes 1..8 on consecutive words, one cycle after each 4th bit; frame_start with
//        code=1, frame_end with code=8; locked falls after the 32nd data bit.
//   2 Random noise with no 1011, then the sync:
//     -> code_valid stays 0 until the sync plus 4 data bits; bits ahead of the sync are
//        never output.
//   3 ready=0 for 12 bits after the first word:
//     -> code stays at word 1, overrun=1, words 2-3 dropped; clr_overrun -> overrun=0.
//   4 enable toggling 1/0 every cycle mid-frame:
//     -> same codes as test 1, at twice the latency; counters frozen in the gaps.
//   5 resync pulse at data bit 6:
//     -> locked=0, pending code unaffected; the next sync restarts at word 1 with
//        frame_start.
//   6 reset_n low mid-word then released:
//     -> all outputs are 0 immediately (async); HUNT resumes; 1011 inside the old
//        payload is not re-locked until after reset.

Source files
------------

// File: rtl/s2p_pkg.sv
// Shared types and default constants for the serial-to-parallel frame path.
package s2p_pkg;

  // Sequencer states: hunting for the sync pattern, or slicing payload words.
  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } s2p_state_t;

  localparam int         DEF_WIDTH           = 4;
  localparam logic [3:0] DEF_SYNC_PATTERN    = 4'b1011;
  localparam int         DEF_WORDS_PER_FRAME = 8;

endpackage

// File: rtl/s2p_out_stage.sv
// Single-entry valid/ready holding register for completed words, with the
// frame marker pulses and the sticky overrun flag.
module s2p_out_stage
  import s2p_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_s,
  input  logic             reset_n,
  input  logic             word_done_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             first_i,
  input  logic             last_i,
  input  logic             ready_i,
  input  logic             clr_overrun_i,
  output logic [WIDTH-1:0] code_o,
  output logic             valid_o,
  output logic             frame_start_o,
  output logic             frame_end_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] code_q;
  logic             valid_q;
  logic             frame_start_q;
  logic             frame_end_q;
  logic             overrun_q;

  logic             xfer;
  logic             accept;
  logic             drop;

  // A new word fits when the register is empty or is being emptied this edge;
  // otherwise the held word wins and the new one is lost.
  always_comb begin
    xfer   = valid_q & ready_i;
    accept = word_done_i & (~valid_q | ready_i);
    drop   = word_done_i & valid_q & ~ready_i;
  end

  // Holding register, markers and sticky overrun (set beats clear).
  always_ff @(posedge clk_s or negedge reset_n) begin
    if (!reset_n) begin
      code_q        <= '0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      if (accept) begin
        code_q  <= word_i;
        valid_q <= 1'b1;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
      frame_start_q <= accept & first_i;
      frame_end_q   <= accept & last_i;
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign code_o        = code_q;
  assign valid_o       = valid_q;
  assign frame_start_o = frame_start_q;
  assign frame_end_o   = frame_end_q;
  assign overrun_o     = overrun_q;

endmodule

// File: rtl/s2p_frame_ctrl.sv
// Frame sequencer: hunts the sync pattern in the serial stream, then slices
// the following bits into WIDTH-bit words, WORDS_PER_FRAME words per frame.
module s2p_frame_ctrl
  import s2p_pkg::*;
#(
  parameter int               WIDTH           = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SYNC_PATTERN    = DEF_SYNC_PATTERN,
  parameter int               WORDS_PER_FRAME = DEF_WORDS_PER_FRAME
) (
  input  logic             clk_s,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             signal,
  input  logic             resync,
  output logic [WIDTH-1:0] code,
  output logic             code_valid,
  input  logic             code_ready,
  output logic             frame_start,
  output logic             frame_end,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic             locked
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WW = $clog2(WORDS_PER_FRAME + 1);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;
  s2p_state_t       state_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [WW-1:0]    word_cnt_q;

  logic             word_end;
  logic             last_word;
  logic             first_word;
  logic             word_done;

  // Next shifter value; the completed word and the sync match both look at it.
  always_comb begin
    sh_d       = {sh_q[WIDTH-2:0], signal};
    word_end   = (state_q == DATA) && (bit_cnt_q == BW'(WIDTH - 1));
    last_word  = (word_cnt_q == WW'(WORDS_PER_FRAME - 1));
    first_word = (word_cnt_q == '0);
    // resync discards a word completing on the same edge.
    word_done  = enable & word_end & ~resync;
  end

  // Shifter, counters and HUNT/DATA sequencing.
  always_ff @(posedge clk_s or negedge reset_n) begin
    if (!reset_n) begin
      sh_q       <= '0;
      state_q    <= HUNT;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      if (enable) begin
        sh_q <= sh_d;
      end
      if (resync) begin
        state_q    <= HUNT;
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
      end else if (enable) begin
        case (state_q)
          HUNT: begin
            if (sh_d == SYNC_PATTERN) begin
              state_q    <= DATA;
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
            end
          end
          DATA: begin
            if (word_end) begin
              bit_cnt_q <= '0;
              if (last_word) begin
                state_q    <= HUNT;
                word_cnt_q <= '0;
              end else begin
                word_cnt_q <= word_cnt_q + WW'(1);
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign locked = (state_q == DATA);

  s2p_out_stage #(
    .WIDTH(WIDTH)
  ) u_out_stage (
    .clk_s         (clk_s),
    .reset_n       (reset_n),
    .word_done_i   (word_done),
    .word_i        (sh_d),
    .first_i       (first_word),
    .last_i        (last_word),
    .ready_i       (code_ready),
    .clr_overrun_i (clr_overrun),
    .code_o        (code),
    .valid_o       (code_valid),
    .frame_start_o (frame_start),
    .frame_end_o   (frame_end),
    .overrun_o     (overrun)
  );

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Directed bench for s2p_frame_ctrl: a vector table for the clean frame plus
// hand-written sequences for noise, stalls, enable gaps, resync and reset.
module tb_s2p_frame_ctrl;

  logic       clk_s = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       signal = 1'b0;
  logic       resync = 1'b0;
  logic [3:0] code;
  logic       code_valid;
  logic       code_ready = 1'b0;
  logic       frame_start;
  logic       frame_end;
  logic       overrun;
  logic       clr_overrun = 1'b0;
  logic       locked;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic       sig;
    logic       rdy;
    logic       valid;
    logic [3:0] code;
    logic       fs;
    logic       fe;
    logic       locked;
    logic       ovr;
  } vec_t;

  vec_t tbl [36];

  s2p_frame_ctrl dut (
    .clk_s       (clk_s),
    .reset_n     (reset_n),
    .enable      (enable),
    .signal      (signal),
    .resync      (resync),
    .code        (code),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .locked      (locked)
  );

  always #5 clk_s = ~clk_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later.
  task automatic step(input logic en, input logic sig, input logic rdy,
                      input logic rs, input logic clr);
    enable = en; signal = sig; code_ready = rdy; resync = rs; clr_overrun = clr;
    @(posedge clk_s);
    #1;
    $display("t=%0t en=%0b sig=%0b rdy=%0b rs=%0b clr=%0b -> valid=%0b code=%h fs=%0b fe=%0b lock=%0b ovr=%0b",
             $time, en, sig, rdy, rs, clr, code_valid, code, frame_start, frame_end, locked, overrun);
  endtask

  task automatic do_reset();
    enable = 0; signal = 0; code_ready = 0; resync = 0; clr_overrun = 0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk_s);
    #1 reset_n = 1'b1;
  endtask

  task automatic send_sync(input logic rdy);
    logic [3:0] sp;
    sp = 4'b1011;
    for (int b = 3; b >= 0; b--) step(1'b1, sp[b], rdy, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] sp;
    logic [3:0] wv;
    logic [3:0] exp_code;
    int j;

    // ---------------- Test 1: clean frame, table driven ----------------
    sp = 4'b1011;
    exp_code = 4'd0;
    for (int s = 0; s < 36; s++) begin
      tbl[s].en  = 1'b1;
      tbl[s].rdy = 1'b1;
      tbl[s].ovr = 1'b0;
      if (s < 4) begin
        tbl[s].sig   = sp[3-s];
        tbl[s].valid = 1'b0;
        tbl[s].fs    = 1'b0;
        tbl[s].fe    = 1'b0;
      end else begin
        j = s - 4;
        wv = 4'(j / 4 + 1);
        tbl[s].sig   = wv[3 - (j % 4)];
        tbl[s].valid = ((j % 4) == 3);
        if ((j % 4) == 3) exp_code = wv;
        tbl[s].fs    = (j == 3);
        tbl[s].fe    = (j == 31);
      end
      tbl[s].code   = exp_code;
      tbl[s].locked = (s >= 3) && (s < 35);
    end

    do_reset();
    chk("rst_valid", code_valid, 0);
    chk("rst_code", code, 0);
    chk("rst_locked", locked, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_fe", frame_end, 0);

    for (int s = 0; s < 36; s++) begin
      step(tbl[s].en, tbl[s].sig, tbl[s].rdy, 1'b0, 1'b0);
      chk($sformatf("t1_valid[%0d]", s), code_valid, tbl[s].valid);
      chk($sformatf("t1_code[%0d]", s), code, tbl[s].code);
      chk($sformatf("t1_fs[%0d]", s), frame_start, tbl[s].fs);
      chk($sformatf("t1_fe[%0d]", s), frame_end, tbl[s].fe);
      chk($sformatf("t1_locked[%0d]", s), locked, tbl[s].locked);
      chk($sformatf("t1_ovr[%0d]", s), overrun, tbl[s].ovr);
    end

    // ---------------- Test 2: noise then sync ----------------
    do_reset();
    begin
      logic [11:0] noise;
      noise = 12'b0011_0011_1000;
      for (int i = 11; i >= 0; i--) begin
        step(1'b1, noise[i], 1'b1, 1'b0, 1'b0);
        chk($sformatf("t2_noise_valid[%0d]", i), code_valid, 0);
        chk($sformatf("t2_noise_locked[%0d]", i), locked, 0);
      end
    end
    send_sync(1'b1);
    chk("t2_locked", locked, 1);
    chk("t2_sync_valid", code_valid, 0);
    wv = 4'b1101;
    for (int b = 3; b >= 0; b--) begin
      step(1'b1, wv[b], 1'b1, 1'b0, 1'b0);
      chk($sformatf("t2_valid[%0d]", b), code_valid, (b == 0));
    end
    chk("t2_code", code, 4'hd);
    chk("t2_fs", frame_start, 1);

    // ---------------- Test 3: consumer stall, overrun ----------------
    do_reset();
    send_sync(1'b1);
    for (int w = 1; w <= 8; w++) begin
      wv = 4'(w);
      for (int b = 0; b < 4; b++) begin
        int idx;
        logic rdy;
        idx = (w - 1) * 4 + b + 1;
        rdy = ((idx >= 4 && idx <= 15) || idx >= 17) ? 1'b0 : 1'b1;
        step(1'b1, wv[3-b], rdy, 1'b0, (idx == 32));
        case (idx)
          4: begin
            chk("t3_w1_valid", code_valid, 1); chk("t3_w1_code", code, 1);
            chk("t3_w1_fs", frame_start, 1);
          end
          7:  chk("t3_ovr_before", overrun, 0);
          8: begin
            chk("t3_drop2_code", code, 1); chk("t3_drop2_valid", code_valid, 1);
            chk("t3_drop2_ovr", overrun, 1);
          end
          12: begin
            chk("t3_drop3_code", code, 1); chk("t3_drop3_valid", code_valid, 1);
          end
          16: begin
            chk("t3_w4_code", code, 4); chk("t3_w4_valid", code_valid, 1);
            chk("t3_w4_fs", frame_start, 0);
          end
          31: chk("t3_locked31", locked, 1);
          32: begin
            chk("t3_last_code", code, 4); chk("t3_last_fe", frame_end, 0);
            chk("t3_last_locked", locked, 0); chk("t3_setwins_ovr", overrun, 1);
          end
          default: ;
        endcase
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_drain_valid", code_valid, 0);
    chk("t3_drain_ovr", overrun, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_clr_ovr", overrun, 0);

    // ---------------- Test 4: enable toggling ----------------
    do_reset();
    send_sync(1'b1);
    for (int w = 1; w <= 8; w++) begin
      wv = 4'(w);
      for (int b = 0; b < 4; b++) begin
        step(1'b1, wv[3-b], 1'b1, 1'b0, 1'b0);
        chk($sformatf("t4_valid[%0d.%0d]", w, b), code_valid, (b == 3));
        chk($sformatf("t4_locked[%0d.%0d]", w, b), locked, !(w == 8 && b == 3));
        if (b == 3) begin
          chk($sformatf("t4_code[%0d]", w), code, w);
          chk($sformatf("t4_fs[%0d]", w), frame_start, (w == 1));
          chk($sformatf("t4_fe[%0d]", w), frame_end, (w == 8));
        end
        step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        chk($sformatf("t4_gap_valid[%0d.%0d]", w, b), code_valid, 0);
      end
    end

    // ---------------- Test 5: resync mid-frame ----------------
    do_reset();
    send_sync(1'b1);
    wv = 4'b0001;
    for (int b = 3; b >= 0; b--) step(1'b1, wv[b], 1'b0, 1'b0, 1'b0);
    chk("t5_w1_valid", code_valid, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_rs_locked", locked, 0);
    chk("t5_rs_valid", code_valid, 1);
    chk("t5_rs_code", code, 1);
    send_sync(1'b0);
    chk("t5_relock", locked, 1);
    chk("t5_relock_code", code, 1);
    wv = 4'b0101;
    for (int b = 3; b >= 0; b--) begin
      step(1'b1, wv[b], 1'b1, 1'b0, 1'b0);
      chk($sformatf("t5_valid[%0d]", b), code_valid, (b == 0));
    end
    chk("t5_code", code, 5);
    chk("t5_fs", frame_start, 1);
    for (int b = 0; b < 3; b++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_rswin_valid", code_valid, 0);
    chk("t5_rswin_ovr", overrun, 0);
    chk("t5_rswin_locked", locked, 0);
    chk("t5_rswin_code", code, 5);

    // ---------------- Test 6: async reset mid-word ----------------
    do_reset();
    send_sync(1'b1);
    wv = 4'b0001;
    for (int b = 3; b >= 0; b--) step(1'b1, wv[b], 1'b0, 1'b0, 1'b0);
    chk("t6_pre_valid", code_valid, 1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", code_valid, 0);
    chk("t6_rst_code", code, 0);
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_ovr", overrun, 0);
    @(posedge clk_s);
    #1 reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_no_stale_lock", locked, 0);
    sp = 4'b1011;
    for (int b = 3; b >= 0; b--) begin
      step(1'b1, sp[b], 1'b1, 1'b0, 1'b0);
      chk($sformatf("t6_lock[%0d]", b), locked, (b == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
